dmem_responder: RTL and testbench

//  Responder (memory) side of the CPU data-memory load/store interface.

---
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data load/store port, with a fixed access latency.
// Optional misalignment check is compiled in by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we;
    logic [IDX_W-1:0] idx;
  } dbg_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             commit;
  logic             mem_we;
  logic             acc_mis;
  logic             err_flag;
  logic [31:0]      mem [DEPTH];
  dbg_t             dbg;
  logic             unused_ok;

  // Handshake: a request is taken when req_i is high at a rising edge in IDLE;
  // ack_o then pulses for exactly one cycle LATENCY cycles later, and req_i is
  // ignored in every non-IDLE cycle, including the ack cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[IDX_W+1:2];
          wdata_d = wdata_i;
          cnt_d   = CNT_INIT;
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = ACK;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (cnt_q == CNT_ONE) begin
          state_d = ACK;
          commit  = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (state_q == IDLE && req_i) begin
      mis_d = (addr_i[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign acc_mis  = mis_d;
  assign err_flag = mis_q;
`else
  assign acc_mis  = 1'b0;
  assign err_flag = 1'b0;
`endif

  // The *_d operands equal the live inputs on a LATENCY==1 accept edge and the
  // latched values otherwise, so the commit edge always sees the right access.
  assign mem_we = commit & we_d & ~acc_mis & ~rst_i;

  always_comb begin
    rdata_d = rdata_q;
    if (commit) begin
      if (acc_mis) begin
        rdata_d = 32'h0;
      end else if (!we_d) begin
        rdata_d = mem[idx_d];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_d] <= wdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o   = (state_q == ACK);
  assign busy_o  = (state_q != IDLE);
  assign rdata_o = rdata_q;
  assign err_o   = ack_o & err_flag;

  assign dbg.state = state_q;
  assign dbg.cnt   = cnt_q;
  assign dbg.we    = we_q;
  assign dbg.idx   = idx_q;

  // Address bits outside the word index are deliberately don't-care.
  assign unused_ok = ^{dbg, addr_i[31:IDX_W+2], addr_i[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder (LATENCY=2 and LATENCY=1 instances).
// Expectations for misaligned accesses follow DMEM_ALIGN_CHECK_EN when it is defined.
module tb_dmem_responder;

  localparam int LAT = 2;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, ack, busy, err;
  logic [31:0] addr, wdata, rdata;
  logic        req1, we1, ack1, busy1, err1;
  logic [31:0] addr1, wdata1, rdata1;

  logic [31:0] exp_q[$];
  logic [31:0] model [int];
  logic [31:0] last_rdata;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .busy_o(busy), .err_o(err)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1), .err_o(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One request on the LATENCY=2 instance; starts and ends in an IDLE cycle.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    int          n;
    int          idx;
    logic        mis;
    logic [31:0] e;
    idx = int'(a[11:2]);
    mis = ALIGN_EN && (a[1:0] != 2'b00);
    if (mis)    e = 32'h0;
    else if (w) e = last_rdata;
    else        e = model[idx];
    if (w && !mis) model[idx] = d;
    exp_q.push_back(e);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_rdata"}, rdata, exp_q.pop_front());
    chk({tag, "_err"}, 32'(err), 32'(mis));
    last_rdata = e;
    tick();
    chk({tag, "_ackoff"}, 32'(ack), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_erroff"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        t_we [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_addr[4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] t_wd  [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
    logic [31:0] t_rd  [4] = '{32'h0, 32'h0, 32'h11, 32'h22};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    last_rdata = 32'h0;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata1", rdata1, 32'h0);
    rst = 1'b0;

    // store then load of the same word
    access("st10", 1'b1, 32'h10, 32'hDEADBEEF);
    access("ld10", 1'b0, 32'h10, 32'h0);

    // held request re-accepted every LATENCY+1 cycles
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("hold_busy%0d", c), 32'((c % 3) != 0), 32'(busy) ^ 32'd0);
      chk($sformatf("hold_ack%0d", c), 32'(ack), 32'((c % 3) == 2));
      if ((c % 3) == 2) chk($sformatf("hold_rdata%0d", c), rdata, 32'hDEADBEEF);
      if (c == 8) req = 1'b0;
      tick();
    end

    // address wrap modulo 4*DEPTH bytes
    access("st1008", 1'b1, 32'h1008, 32'h00001234);
    access("ld8", 1'b0, 32'h8, 32'h0);

    // reset in the WAIT cycle aborts an uncommitted store
    access("st20z", 1'b1, 32'h20, 32'h0);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    tick();
    req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort_ack%0d", c), 32'(ack), 32'd0);
      chk($sformatf("abort_busy%0d", c), 32'(busy), 32'd0);
      tick();
    end
    chk("abort_rdata", rdata, 32'h0);
    last_rdata = 32'h0;
    access("ld20", 1'b0, 32'h20, 32'h0);

    // misaligned store and load
    access("st13", 1'b1, 32'h13, 32'h5A5A0000);
    access("ld10b", 1'b0, 32'h10, 32'h0);
    access("ld11", 1'b0, 32'h11, 32'h0);

    // LATENCY=1: back-to-back requests with req held high
    req1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if ((c % 2) == 0) begin
        we1 = t_we[c/2]; addr1 = t_addr[c/2]; wdata1 = t_wd[c/2];
        exp_q.push_back(t_rd[c/2]);
      end
      chk($sformatf("l1_ack%0d", c), 32'(ack1), 32'(c % 2));
      chk($sformatf("l1_busy%0d", c), 32'(busy1), 32'(c % 2));
      if ((c % 2) == 1) begin
        chk($sformatf("l1_rdata%0d", c), rdata1, exp_q.pop_front());
        chk($sformatf("l1_err%0d", c), 32'(err1), 32'd0);
      end
      if (c == 7) req1 = 1'b0;
      tick();
    end
    chk("l1_idle", 32'(busy1), 32'd0);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
